// File: rtl/ysyx_22050518_mul.sv
// Iterative 64-bit RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW), shift-add on magnitudes.
// Ports: clk, rst_n (sync, active-low), multiplicand, multiplier, mul_valid, mulw, mul_signed[1:0],
//        flush -> out_ready, out_valid, result_hi, result_lo. Define YSYX_22050518_MUL_RADIX4_EN for radix-4.
module ysyx_22050518_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] multiplicand,
  input  logic [63:0] multiplier,
  input  logic        mul_valid,
  input  logic        mulw,
  input  logic [1:0]  mul_signed,
  input  logic        flush,
  output logic        out_ready,
  output logic        out_valid,
  output logic [63:0] result_hi,
  output logic [63:0] result_lo
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

`ifdef YSYX_22050518_MUL_RADIX4_EN
  localparam int          STEP   = 2;
  localparam logic [5:0]  LAST_D = 6'd31;
  localparam logic [5:0]  LAST_W = 6'd15;
`else
  localparam int          STEP   = 1;
  localparam logic [5:0]  LAST_D = 6'd63;
  localparam logic [5:0]  LAST_W = 6'd31;
`endif

  state_t        state, state_nxt;
  logic [5:0]    cnt;
  logic [127:0]  acc, mcand, acc_nxt, prod;
  logic [63:0]   mplr;
  logic          neg, mulw_q;
  logic          accept, last;
  logic          sa, sb;
  logic [63:0]   ext_a, ext_b, mag_a, mag_b;
`ifdef YSYX_22050518_MUL_RADIX4_EN
  logic [127:0]  m3;
`endif

  // 01 is treated as fully unsigned
  assign sa = mul_signed[1];
  assign sb = mul_signed[1] & mul_signed[0];

  assign ext_a = !mulw ? multiplicand :
                 sa ? {{32{multiplicand[31]}}, multiplicand[31:0]} :
                      {32'b0, multiplicand[31:0]};
  assign ext_b = !mulw ? multiplier :
                 sb ? {{32{multiplier[31]}}, multiplier[31:0]} :
                      {32'b0, multiplier[31:0]};

  // -2^63 maps to 2^63, which is exact as an unsigned magnitude
  assign mag_a = (sa && ext_a[63]) ? (~ext_a + 64'd1) : ext_a;
  assign mag_b = (sb && ext_b[63]) ? (~ext_b + 64'd1) : ext_b;

  assign accept    = (state == IDLE) && mul_valid && !flush;
  assign last      = cnt == (mulw_q ? LAST_W : LAST_D);
  assign out_ready = state == IDLE;
  assign out_valid = state == DONE;

  always_comb begin
    acc_nxt = acc;
`ifdef YSYX_22050518_MUL_RADIX4_EN
    case (mplr[1:0])
      2'b01:   acc_nxt = acc + mcand;
      2'b10:   acc_nxt = acc + (mcand << 1);
      2'b11:   acc_nxt = acc + m3;
      default: acc_nxt = acc;
    endcase
`else
    if (mplr[0]) acc_nxt = acc + mcand;
`endif
    prod = neg ? (~acc_nxt + 128'd1) : acc_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      neg       <= 1'b0;
      mulw_q    <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
`ifdef YSYX_22050518_MUL_RADIX4_EN
      m3        <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {64'b0, mag_a};
        mplr   <= mag_b;
        neg    <= (sa & ext_a[63]) ^ (sb & ext_b[63]);
        mulw_q <= mulw;
`ifdef YSYX_22050518_MUL_RADIX4_EN
        m3     <= {64'b0, mag_a} + {63'b0, mag_a, 1'b0};
`endif
      end else if (state == BUSY && !flush) begin
        acc   <= acc_nxt;
        mcand <= mcand << STEP;
        mplr  <= mplr >> STEP;
        cnt   <= last ? 6'd0 : cnt + 6'd1;
`ifdef YSYX_22050518_MUL_RADIX4_EN
        m3    <= m3 << STEP;
`endif
        if (last) begin
          result_hi <= mulw_q ? 64'd0 : prod[127:64];
          result_lo <= mulw_q ? {{32{prod[31]}}, prod[31:0]}
                              : prod[63:0];
        end
      end else if (flush) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050518_mul.sv
// Self-checking bench for ysyx_22050518_mul: directed vectors, random ops vs
// a 128-bit arithmetic model, latency, flush and reset-abort behaviour.
module tb_ysyx_22050518_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] multiplicand, multiplier;
  logic        mul_valid, mulw, flush;
  logic [1:0]  mul_signed;
  logic        out_ready, out_valid;
  logic [63:0] result_hi, result_lo;

  int n_checks = 0;
  int n_fails  = 0;
  logic [127:0] last_exp = '0;

  always #5 clk = ~clk;

  ysyx_22050518_mul dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .mul_valid    (mul_valid),
    .mulw         (mulw),
    .mul_signed   (mul_signed),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic w,
                                         input logic [1:0] s);
    logic sa, sb;
    logic [63:0] xa, xb;
    logic [127:0] ea, eb, p;
    sa = s == 2'b11 || s == 2'b10;
    sb = s == 2'b11;
    xa = a;
    xb = b;
    if (w) begin
      xa = sa ? 64'(signed'(a[31:0])) : 64'(a[31:0]);
      xb = sb ? 64'(signed'(b[31:0])) : 64'(b[31:0]);
    end
    ea = sa ? 128'(signed'(xa)) : 128'(xa);
    eb = sb ? 128'(signed'(xb)) : 128'(xb);
    p  = ea * eb;
    if (w) return {64'd0, 64'(signed'(p[31:0]))};
    return p;
  endfunction

  function automatic int exp_lat(input logic w);
`ifdef YSYX_22050518_MUL_RADIX4_EN
    return w ? 17 : 33;
`else
    return w ? 33 : 65;
`endif
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge of the
  // first idle cycle after DONE so the next call is back-to-back.
  task automatic run_op(input string tag, input logic [63:0] a,
                        input logic [63:0] b, input logic w,
                        input logic [1:0] s);
    int k;
    logic [127:0] e;
    e = model(a, b, w, s);
    chk({tag, " ready"}, 128'(out_ready), 128'd1);
    multiplicand = a;
    multiplier   = b;
    mulw         = w;
    mul_signed   = s;
    mul_valid    = 1'b1;
    @(negedge clk);
    mul_valid    = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    chk({tag, " busy"}, 128'(out_ready), 128'd0);
    k = 1;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 128'(k), 128'(exp_lat(w)));
    chk({tag, " result"}, {result_hi, result_lo}, e);
    last_exp = e;
    @(negedge clk);
    chk({tag, " valid_one"}, 128'(out_valid), 128'd0);
    chk({tag, " ready_back"}, 128'(out_ready), 128'd1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk({tag, " no_valid"}, 128'(seen), 128'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    rst_n = 1'b0;
    mul_valid = 1'b0;
    mulw = 1'b0;
    flush = 1'b0;
    mul_signed = 2'b00;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst ready", 128'(out_ready), 128'd1);
    chk("rst valid", 128'(out_valid), 128'd0);
    chk("rst result", {result_hi, result_lo}, 128'd0);

    run_op("umax_x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 2'b00);
    chk("umax_x2 const", {result_hi, result_lo},
        {64'h1, 64'hFFFF_FFFF_FFFF_FFFE});
    run_op("m3_x7", -64'sd3, 64'd7, 1'b0, 2'b11);
    chk("m3_x7 const", {result_hi, result_lo},
        {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB});
    run_op("hsu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 2'b10);
    chk("hsu const", {result_hi, result_lo},
        {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});
    run_op("hu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 2'b00);
    run_op("s01", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 2'b01);
    run_op("mulw", 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 1'b1, 2'b11);
    chk("mulw const", {result_hi, result_lo},
        {64'h0, 64'hFFFF_FFFF_FFFF_FFFE});
    run_op("ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           1'b0, 2'b11);
    chk("ovf const", {result_hi, result_lo},
        {64'h0, 64'h8000_0000_0000_0000});
    run_op("w_min", 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
           1'b1, 2'b11);

    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 6 == 5) ra = 64'h8000_0000_0000_0000;
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)));
    end

    multiplicand = 64'h1234_5678_9ABC_DEF0;
    multiplier   = 64'hFEDC_BA98_7654_3210;
    mulw = 1'b0;
    mul_signed = 2'b11;
    mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush ready", 128'(out_ready), 128'd1);
    chk("flush keep", {result_hi, result_lo}, last_exp);
    watch_no_valid("flush", 80);
    chk("flush keep2", {result_hi, result_lo}, last_exp);
    run_op("5x6", 64'd5, 64'd6, 1'b0, 2'b00);
    chk("5x6 const", {result_hi, result_lo}, 128'd30);

    multiplicand = 64'd7;
    multiplier = 64'd9;
    mul_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    flush = 1'b0;
    chk("vflush ready", 128'(out_ready), 128'd1);
    watch_no_valid("vflush", 70);
    chk("vflush keep", {result_hi, result_lo}, 128'd30);

    multiplicand = 64'd11;
    multiplier = 64'd13;
    mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst ready", 128'(out_ready), 128'd1);
    chk("mrst result", {result_hi, result_lo}, 128'd0);
    watch_no_valid("mrst", 70);
    run_op("post_rst", 64'd11, 64'd13, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22050518_mul.md
# ysyx_22050518_mul

Iterative 64-bit integer multiplier for the NPC execute stage; companion to the iterative divider, using the same request/response handshake and flush semantics. Covers RV64M MUL, MULH, MULHSU, MULHU and MULW. Operands are converted to magnitudes, multiplied unsigned by shift-add, and the 128-bit product is negated when the result is negative.

## Interface
- No parameters.
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- multiplicand  in  64  operand A (rs1).
- multiplier  in  64  operand B (rs2).
- mul_valid  in  1  request strobe; accepted when `mul_valid && out_ready`.
- mulw  in  1  32-bit word op; uses operand bits [31:0] only.
- mul_signed  in  2  [1]=A signed, [0]=B signed; 11 MUL/MULH/MULW, 10 MULHSU, 00 MULHU; 01 treated as 00.
- flush  in  1  synchronous abort; state goes to IDLE.
- out_ready  out  1  high in IDLE; unit can accept.
- out_valid  out  1  one-cycle result strobe.
- result_hi  out  64  product[127:64]; 0 for mulw.
- result_lo  out  64  product[63:0]; for mulw, sext(product[31:0]).

## Operation
- States: IDLE, BUSY, DONE. IDLE→BUSY on accept; BUSY→DONE when the iteration counter reaches N-1; DONE→IDLE unconditionally.
- On accept, latch mulw and the signedness bits.
- On accept, form 64-bit magnitudes. For mulw, first sign- or zero-extend bits [31:0] per signedness.
- On accept, latch neg = signA&A_msb XOR signB&B_msb, where msb is bit 31 for mulw and bit 63 otherwise.
- On accept, clear the 128-bit accumulator.
- Each BUSY cycle (radix-2):
  - if multiplier LSB is 1, add the shifted multiplicand to the accumulator;
  - shift the multiplicand left 1;
  - shift the multiplier right 1.
- N = 64, or 32 for mulw.
- Entering DONE, register product = neg ? ~acc+1 : acc, and drive result_hi/result_lo from it.
- Results hold until the next completed operation.
- mul_valid while not in IDLE is ignored; there is no queuing.
- flush has priority over accept. A request with flush high in the same cycle is dropped.
- flush in BUSY drops the operation: no out_valid, and result registers are unchanged.
- flush in DONE: out_valid is still high that cycle (state-decoded). The consumer gates it with its own flush.
- Reset mid-operation behaves as flush and also clears the results.
- Overflow case 0x8000_0000_0000_0000 × -1 (signed) wraps per RISC-V: the magnitude path yields 2^63, and negation gives the correct 128-bit value.

## Timing
- Reset values: state IDLE, out_ready=1, out_valid=0, result_hi=0, result_lo=0, counter=0.
- Accept at edge E0. BUSY occupies cycles 1..N. out_valid is high in cycle N+1 only. out_ready is high again in cycle N+2.
- Latency from accept edge to out_valid:
  - radix-2: 65 cycles, or 33 for mulw;
  - radix-4: 33 cycles, or 17 for mulw.
- out_ready and out_valid are decoded from the state register only; no input-to-output combinational path.
- Back-to-back: a new request can be accepted in the first IDLE cycle after DONE.

## Configuration
- YSYX_22050518_MUL_RADIX4_EN defined: each BUSY cycle retires 2 multiplier bits.
  - Per step, add 0, 1×, 2× or 3× the multiplicand; 3× comes from a register precomputed at accept.
  - Shifts are by 2.
  - N = 32, or 16 for mulw.
- Undefined: radix-2 as above.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- A=0xFFFF_FFFF_FFFF_FFFF, B=2, mul_signed=00 -> hi=0x1, lo=0xFFFF_FFFF_FFFF_FFFE. out_valid exactly 65 cycles after accept (33 with RADIX4), high for one cycle.
- A=-3, B=7, mul_signed=11 -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFEB.
- A=-1, B=2, mul_signed=10 -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFFE. Same operands with 00 -> hi=0x1, lo=0xFFFF_FFFF_FFFF_FFFE.
- mulw=1, A=0xDEAD_BEEF_7FFF_FFFF, B=2, mul_signed=11 -> lo=0xFFFF_FFFF_FFFF_FFFE, hi=0. out_valid at cycle 33 (17 with RADIX4).
- A=0x8000_0000_0000_0000, B=-1, mul_signed=11 -> hi=0x0, lo=0x8000_0000_0000_0000.
- Flush pulse at BUSY cycle 10 -> no out_valid, out_ready=1 next cycle, results unchanged.
  - Follow with 5×6 unsigned -> lo=30, hi=0.
  - mul_valid+flush in the same cycle -> request not accepted.
